// File: rtl/j4_mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the j4 data port (A)
// and the loader/debug port (B). Each transaction is held-request / one-cycle-ack.
module j4_mem_arb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Port A: j4 core
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic              a_ack,
    output logic [WIDTH-1:0]  a_rdata,
    // Port B: loader/debug
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic              b_ack,
    output logic [WIDTH-1:0]  b_rdata,
    // RAM side
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                win_q, win_d;    // 1: port B owns the transaction in flight
    logic                last_q, last_d;  // 1: port B was granted most recently
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [WIDTH-1:0]    a_rdata_q, a_rdata_d;
    logic [WIDTH-1:0]    b_rdata_q, b_rdata_d;
    logic                grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        // On a tie the port not granted last time wins
        grant_b     = b_req & (~a_req | ~last_q);

        case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    win_d       = grant_b;
                    last_d      = grant_b;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_b ? b_we    : a_we;
                    mem_addr_d  = grant_b ? b_addr  : a_addr;
                    mem_wdata_d = grant_b ? b_wdata : a_wdata;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (mem_we_q) begin
                    a_ack_d = ~win_q;
                    b_ack_d = win_q;
                    state_d = StResp;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (win_q) begin
                    b_rdata_d = mem_rdata;
                end else begin
                    a_rdata_d = mem_rdata;
                end
                a_ack_d = ~win_q;
                b_ack_d = win_q;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/j4_mem_arb.md
# j4_mem_arb

Two-port arbiter that shares one single-port synchronous RAM between the j4 data port (io_re/io_we/io_ptr traffic) and a loader/debug port. Each requester issues a held request and receives a one-cycle acknowledge. Grants alternate round-robin when both ports request. The block sits between the j4 core and the system RAM, replacing direct io_* wiring to the memory array.

## Interface
- WIDTH, 16, data word width (matches `WIDTH)
- AWIDTH, 16, RAM address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  port A (j4 core) request, held until a_ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  AWIDTH  port A address
- a_wdata  in  WIDTH  port A write data
- a_ack  out  1  port A completion pulse, one cycle
- a_rdata  out  WIDTH  port A read data, valid from a_ack cycle, held until next port A read completes
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: port B (loader/debug), identical semantics
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  AWIDTH  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid the cycle after mem_en & !mem_we
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: if neither req, stay. Otherwise pick a winner, latch its we/addr/wdata into the mem_* registers, record winner, go ACCESS.
- Arbitration: only one requester → it wins. Both → the port not granted last wins. The last-grant pointer resets to B, so A wins the first tie after reset.
- ACCESS: mem_en=1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the latch. Write → RESP. Read → CAPTURE.
- CAPTURE: mem_en=0. Load mem_rdata into the winner's rdata register at the end of the cycle. Go RESP.
- RESP: assert the winner's ack only. Go IDLE.
- mem_addr/mem_wdata/mem_we keep their last values when mem_en=0. Only mem_en qualifies them.
- The other port's rdata is never modified by a transaction it did not win.
- Command fields are sampled only in IDLE. Changes to req/we/addr/wdata after sampling do not affect the transaction in flight.
- Withdrawing req before ack is a protocol violation. The latched transaction still completes and ack still pulses.
- A requester may keep req high after ack with a new command. It is re-arbitrated in the following IDLE cycle.
- Reset (asynchronous, any state): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, last-grant=B. An access interrupted by reset is aborted and no ack is issued. Whether the RAM write occurs depends on whether the reset precedes the clock edge ending ACCESS.

## Timing
- Request sampled in IDLE at cycle T.
- Write: mem_en/mem_we high in T+1, ack in T+2. Throughput is one write per 3 cycles.
- Read: mem_en high in T+1, mem_rdata captured at end of T+2, ack and rdata valid in T+3. Throughput is one read per 4 cycles.
- Ack, rdata and all mem_* outputs are registered. There is no combinational path from any input to any output.
- The requester observes ack at the edge ending RESP. The next IDLE cycle samples the updated req.
- Under continuous requests from both ports, grants strictly alternate A, B, A, B. Neither port waits more than one competing transaction.
- busy rises the cycle after the request is sampled and falls in the cycle after RESP.

## Test plan
- Reset mid-ACCESS of an A write (addr 0x0010, data 0xBEEF): mem_en drops asynchronously, no a_ack, FSM IDLE. After release, an A read of 0x0010 completes cleanly.
- Single A write 0x0042←0x1234, then A read 0x0042: mem_en pulses in T+1, a_ack in T+2. The read's a_ack comes 3 cycles after sampling with a_rdata=0x1234. b_ack stays 0 throughout.
- A and B both request continuously from reset for 8 transactions (A writes addr 0x0000–0x0003, B reads 0x0100–0x0103): grant order is A, B, A, B, …, and every ack appears exactly at the stated latency.
- B write 0x0100←0xCAFE then B read 0x0100 while A holds a stalled read of 0x0200 (preloaded 0x5555): a_rdata=0x5555 is unaffected by B traffic, and b_rdata=0xCAFE.
- A changes a_addr from 0x0020 to 0x0030 during ACCESS: the RAM sees mem_addr=0x0020 only.
- Only B requests for 4 back-to-back writes with b_req held high: one mem_en every 3 cycles, 4 b_acks, and busy low only in the IDLE cycles.
